event_readout_sequencer: RTL and testbench

EVENT_READOUT_SEQUENCER -- requirements
Module: event_readout_sequencer

---
 rtl/koto_ofc_pkg.sv | 22 ++
 rtl/sample_skid_fifo.sv | 39 +++
 rtl/event_readout_sequencer.sv | 165 ++++++++++++++++
 tb/tb_event_readout_sequencer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/koto_ofc_pkg.sv
// Shared types and framing constants for the OFC event readout path.
package koto_ofc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_STREAM,
        ST_TRAILER
    } seq_state_t;

    localparam logic [3:0] HDR_MARK = 4'hA;
    localparam logic [3:0] TRL_MARK = 4'hC;

    function automatic logic [15:0] header_word(input logic [11:0] evt_no);
        return {HDR_MARK, evt_no};
    endfunction

    function automatic logic [15:0] trailer_word(input logic ovf, input logic [8:0] slot);
        return {TRL_MARK, 2'b00, ovf, slot};
    endfunction

endpackage

// File: rtl/sample_skid_fifo.sv
// Two-entry sample buffer between the RAM read port and the output stream.
module sample_skid_fifo #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= '0;
        end else begin
            if (wr_en) begin
                r_mem[r_wptr] <= wr_data;
                r_wptr        <= ~r_wptr;
            end
            if (rd_en) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, wr_en} - {1'b0, rd_en};
        end
    end

    assign rd_data = r_mem[r_rptr];
    assign count   = r_count;

endmodule

// File: rtl/event_readout_sequencer.sv
// Drains written event slots from the buffer RAM as header / NSAMPLE samples /
// trailer frames on a valid-ready stream, tracking pending events.
module event_readout_sequencer
    import koto_ofc_pkg::*;
#(
    parameter int NSAMPLE = 64,
    parameter int NSLOT   = 64,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig_accepted,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic              read_complete,
    output logic [5:0]        n_pending,
    output logic              pend_overflow
);

    localparam int SLOT_W = $clog2(NSLOT);
    localparam int IDX_W  = $clog2(NSAMPLE + 1);

    seq_state_t        r_state;
    logic [5:0]        r_n_pending;
    logic              r_pend_overflow;
    logic [11:0]       r_evt_no;
    logic [SLOT_W-1:0] r_rd_slot;
    logic [IDX_W-1:0]  r_sample_idx;
    logic [IDX_W-1:0]  r_tx_cnt;
    logic              r_rd_pend;
    logic              r_read_complete;

    logic [DATA_W-1:0] w_fifo_data;
    logic [1:0]        w_fifo_count;
    logic [1:0]        w_occ;
    logic              w_start;
    logic              w_fifo_wr;
    logic              w_fifo_rd;
    logic              w_bypass;

    assign w_start = (r_state == ST_IDLE) && (r_n_pending != '0);
    assign w_occ   = w_fifo_count + {1'b0, r_rd_pend};

    // With the buffer empty, returning RAM data is presented directly so the
    // first sample leaves two cycles after the header; it is only captured if stalled.
    assign w_bypass  = (r_state == ST_STREAM) && (w_fifo_count == 2'd0) && r_rd_pend && tx_ready;
    assign w_fifo_wr = r_rd_pend && !w_bypass;
    assign w_fifo_rd = (r_state == ST_STREAM) && (w_fifo_count != 2'd0) && tx_ready;

    assign mem_ren   = (r_state == ST_STREAM) && (r_sample_idx != IDX_W'(NSAMPLE)) && (w_occ < 2'd2);
    assign mem_raddr = ADDR_W'(r_rd_slot) * ADDR_W'(NSAMPLE) + ADDR_W'(r_sample_idx);

    sample_skid_fifo #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (w_fifo_wr),
        .wr_data(mem_rdata),
        .rd_en  (w_fifo_rd),
        .rd_data(w_fifo_data),
        .count  (w_fifo_count)
    );

    always_comb begin
        tx_valid = 1'b0;
        tx_sof   = 1'b0;
        tx_eof   = 1'b0;
        tx_data  = '0;
        case (r_state)
            ST_HEADER: begin
                tx_valid = 1'b1;
                tx_sof   = 1'b1;
                tx_data  = DATA_W'(header_word(r_evt_no));
            end
            ST_STREAM: begin
                tx_valid = (w_fifo_count != 2'd0) || r_rd_pend;
                if (w_fifo_count != 2'd0) begin
                    tx_data = w_fifo_data;
                end else if (r_rd_pend) begin
                    tx_data = mem_rdata;
                end
            end
            ST_TRAILER: begin
                tx_valid = 1'b1;
                tx_eof   = 1'b1;
                tx_data  = DATA_W'(trailer_word(r_pend_overflow, 9'(r_rd_slot)));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_n_pending     <= '0;
            r_pend_overflow <= 1'b0;
            r_evt_no        <= '0;
            r_rd_slot       <= '0;
            r_sample_idx    <= '0;
            r_tx_cnt        <= '0;
            r_rd_pend       <= 1'b0;
            r_read_complete <= 1'b0;
        end else begin
            r_rd_pend       <= mem_ren;
            r_read_complete <= (r_state == ST_TRAILER) && tx_ready;

            if (trig_accepted && !w_start) begin
                if (r_n_pending == 6'd63) begin
                    r_pend_overflow <= 1'b1;
                end else begin
                    r_n_pending <= r_n_pending + 6'd1;
                end
            end else if (!trig_accepted && w_start) begin
                r_n_pending <= r_n_pending - 6'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (tx_ready) begin
                        r_state      <= ST_STREAM;
                        r_evt_no     <= r_evt_no + 12'd1;
                        r_sample_idx <= '0;
                        r_tx_cnt     <= '0;
                    end
                end
                ST_STREAM: begin
                    if (mem_ren) begin
                        r_sample_idx <= r_sample_idx + 1'b1;
                    end
                    if (tx_valid && tx_ready) begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                        if (r_tx_cnt == IDX_W'(NSAMPLE - 1)) begin
                            r_state <= ST_TRAILER;
                        end
                    end
                end
                ST_TRAILER: begin
                    if (tx_ready) begin
                        r_state   <= ST_IDLE;
                        r_rd_slot <= r_rd_slot + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign read_complete = r_read_complete;
    assign n_pending     = r_n_pending;
    assign pend_overflow = r_pend_overflow;

endmodule

// File: tb/tb_event_readout_sequencer.sv
// Directed bench for event_readout_sequencer with a small RAM model and transfer log.
module tb_event_readout_sequencer;

    localparam int NS = 4;
    localparam int NSL = 8;
    localparam int DW = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trig = 1'b0;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] mem_rdata;
    logic          mem_ren;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_sof;
    logic          tx_eof;
    logic          read_complete;
    logic [5:0]    n_pending;
    logic          pend_overflow;

    int checks = 0;
    int errors = 0;

    event_readout_sequencer #(
        .NSAMPLE(NS),
        .NSLOT  (NSL),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trig_accepted(trig),
        .mem_rdata    (mem_rdata),
        .mem_ren      (mem_ren),
        .mem_raddr    (mem_raddr),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_sof       (tx_sof),
        .tx_eof       (tx_eof),
        .read_complete(read_complete),
        .n_pending    (n_pending),
        .pend_overflow(pend_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ram_word(input logic [AW-1:0] a);
        return 16'h5A00 ^ ({11'd0, a} * 16'h0103);
    endfunction

    // {sof, eof, data} expected for word k of an event (0 header, NS+1 trailer)
    function automatic logic [17:0] exp_word(input int evt, input int slot, input int k, input logic ovf);
        logic [11:0] e;
        logic [8:0]  s;
        logic [AW-1:0] a;
        e = 12'(evt);
        s = 9'(slot);
        a = AW'(slot * NS + k - 1);
        if (k == 0) return {2'b10, 4'hA, e};
        if (k == NS + 1) return {2'b01, 4'hC, 2'b00, ovf, s};
        return {2'b00, ram_word(a)};
    endfunction

    always @(posedge clk) mem_rdata <= mem_ren ? ram_word(mem_raddr) : 16'hDEAD;

    int          cyc = 0;
    logic [17:0] xq[$];
    int          xc[$];
    int          rcq[$];
    int          occ = 0;
    int          occ_viol = 0;
    int          stab_viol = 0;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_word = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            occ        <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!tx_valid || {tx_sof, tx_eof, tx_data} !== prev_word))
                stab_viol <= stab_viol + 1;
            if (mem_ren && occ >= 2)
                occ_viol <= occ_viol + 1;
            if (tx_valid && tx_ready) begin
                xq.push_back({tx_sof, tx_eof, tx_data});
                xc.push_back(cyc);
            end
            if (read_complete)
                rcq.push_back(cyc);
            occ <= occ + (mem_ren ? 1 : 0) - ((tx_valid && tx_ready && !tx_sof && !tx_eof) ? 1 : 0);
            prev_stall <= tx_valid && !tx_ready;
            prev_word  <= {tx_sof, tx_eof, tx_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        trig = 1'b0;
        tx_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_rc(input int n, input int budget, input string name);
        for (int i = 0; i < budget && rcq.size() < n; i++) tick();
        checks++;
        if (rcq.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d read_complete want %0d", name, rcq.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        trig = 1'b1;
        tx_ready = 1'b1;
        repeat (3) tick();
        #2;
        checks++;
        if ({tx_valid, tx_sof, tx_eof, mem_ren, read_complete, pend_overflow} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {tx_valid, tx_sof, tx_eof, mem_ren, read_complete, pend_overflow});
        end
        checks++;
        if (tx_data !== 16'h0) begin errors++; $display("FAIL reset_tx_data: got %h want 0000", tx_data); end
        checks++;
        if (mem_raddr !== 5'd0) begin errors++; $display("FAIL reset_raddr: got %0d want 0", mem_raddr); end
        checks++;
        if (n_pending !== 6'd0) begin errors++; $display("FAIL reset_n_pending: got %0d want 0", n_pending); end
        rst = 1'b0;
        trig = 1'b0;
        tx_ready = 1'b0;
    endtask

    task automatic test_single_event();
        int b, rb, t0, h;
        do_reset();
        b = xq.size();
        rb = rcq.size();
        tx_ready = 1'b1;
        trig = 1'b1;
        t0 = cyc;
        tick();
        trig = 1'b0;
        #2;
        checks++;
        if (n_pending !== 6'd1) begin errors++; $display("FAIL single_pending: got %0d want 1", n_pending); end
        wait_rc(rb + 1, 40, "single");
        repeat (3) tick();
        checks++;
        if (xq.size() - b != NS + 2) begin
            errors++;
            $display("FAIL single_count: got %0d transfers want %0d", xq.size() - b, NS + 2);
        end else begin
            h = t0 + 2;
            for (int k = 0; k < NS + 2; k++) begin
                checks++;
                if (xq[b+k] !== exp_word(0, 0, k, 1'b0) || xc[b+k] != h + ((k == 0) ? 0 : k + 1)) begin
                    errors++;
                    $display("FAIL single_word%0d: got %h at cycle %0d want %h at cycle %0d",
                             k, xq[b+k], xc[b+k], exp_word(0, 0, k, 1'b0), h + ((k == 0) ? 0 : k + 1));
                end
            end
            checks++;
            if (rcq.size() - rb != 1 || rcq[rb] != h + NS + 3) begin
                errors++;
                $display("FAIL single_read_complete: got %0d pulses first at %0d want 1 at %0d",
                         rcq.size() - rb, rcq[rb], h + NS + 3);
            end
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        tx_ready = 1'b0;
        trig = 1'b1;
        tick();
        tick();
        trig = 1'b0;
        #2;
        checks++;
        if (n_pending !== 6'd1) begin errors++; $display("FAIL same_cycle_pending: got %0d want 1", n_pending); end
        checks++;
        if ({tx_valid, tx_sof, tx_data} !== {2'b11, 16'hA000}) begin
            errors++;
            $display("FAIL same_cycle_header: got %b %h want 11 a000", {tx_valid, tx_sof}, tx_data);
        end
    endtask

    task automatic test_back_to_back();
        int b, rb;
        logic [5:0] seen [3];
        logic [5:0] want [3];
        do_reset();
        b = xq.size();
        rb = rcq.size();
        tx_ready = 1'b1;
        // the first start coincides with the second pulse, so the count holds at 1 there
        want[0] = 6'd1; want[1] = 6'd1; want[2] = 6'd2;
        for (int i = 0; i < 3; i++) begin
            trig = 1'b1;
            tick();
            #2;
            seen[i] = n_pending;
        end
        trig = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (seen[i] !== want[i]) begin
                errors++;
                $display("FAIL b2b_pending%0d: got %0d want %0d", i, seen[i], want[i]);
            end
        end
        wait_rc(rb + 3, 120, "b2b");
        tick();
        checks++;
        if (xq.size() - b != 3 * (NS + 2)) begin
            errors++;
            $display("FAIL b2b_count: got %0d transfers want %0d", xq.size() - b, 3 * (NS + 2));
        end else begin
            for (int e = 0; e < 3; e++) begin
                for (int k = 0; k < NS + 2; k++) begin
                    checks++;
                    if (xq[b + e*(NS+2) + k] !== exp_word(e, e, k, 1'b0)) begin
                        errors++;
                        $display("FAIL b2b_evt%0d_word%0d: got %h want %h",
                                 e, k, xq[b + e*(NS+2) + k], exp_word(e, e, k, 1'b0));
                    end
                end
            end
        end
        checks++;
        if (n_pending !== 6'd0) begin errors++; $display("FAIL b2b_final_pending: got %0d want 0", n_pending); end
    endtask

    task automatic test_backpressure();
        int b, rb, ov0, st0;
        do_reset();
        b = xq.size();
        rb = rcq.size();
        ov0 = occ_viol;
        st0 = stab_viol;
        trig = 1'b1;
        tick();
        tick();
        trig = 1'b0;
        for (int i = 0; i < 400 && rcq.size() < rb + 2; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            tick();
        end
        tx_ready = 1'b0;
        checks++;
        if (rcq.size() < rb + 2) begin errors++; $display("FAIL bp_timeout: got %0d read_complete want 2", rcq.size() - rb); end
        tick();
        checks++;
        if (xq.size() - b != 2 * (NS + 2)) begin
            errors++;
            $display("FAIL bp_count: got %0d transfers want %0d", xq.size() - b, 2 * (NS + 2));
        end else begin
            for (int e = 0; e < 2; e++) begin
                for (int k = 0; k < NS + 2; k++) begin
                    checks++;
                    if (xq[b + e*(NS+2) + k] !== exp_word(e, e, k, 1'b0)) begin
                        errors++;
                        $display("FAIL bp_evt%0d_word%0d: got %h want %h",
                                 e, k, xq[b + e*(NS+2) + k], exp_word(e, e, k, 1'b0));
                    end
                end
            end
        end
        checks++;
        if (occ_viol != ov0) begin errors++; $display("FAIL bp_overfill: got %0d overfilling reads want 0", occ_viol - ov0); end
        checks++;
        if (stab_viol != st0) begin errors++; $display("FAIL bp_stability: got %0d unstable stalls want 0", stab_viol - st0); end
    endtask

    task automatic test_overflow();
        int b, rb;
        do_reset();
        b = xq.size();
        rb = rcq.size();
        tx_ready = 1'b0;
        trig = 1'b1;
        // the first pulse is absorbed by the event start, so 64 pulses leave 63 pending
        repeat (64) tick();
        #2;
        checks++;
        if ({pend_overflow, n_pending} !== {1'b0, 6'd63}) begin
            errors++;
            $display("FAIL ovf_at_63: got ovf=%b n=%0d want ovf=0 n=63", pend_overflow, n_pending);
        end
        tick();
        trig = 1'b0;
        #2;
        checks++;
        if ({pend_overflow, n_pending} !== {1'b1, 6'd63}) begin
            errors++;
            $display("FAIL ovf_saturate: got ovf=%b n=%0d want ovf=1 n=63", pend_overflow, n_pending);
        end
        tx_ready = 1'b1;
        wait_rc(rb + 1, 40, "ovf");
        checks++;
        if (xq.size() - b < NS + 2) begin
            errors++;
            $display("FAIL ovf_count: got %0d transfers want %0d", xq.size() - b, NS + 2);
        end else begin
            checks++;
            if (xq[b] !== 18'h2A000) begin errors++; $display("FAIL ovf_header: got %h want 2a000", xq[b]); end
            checks++;
            if (xq[b + NS + 1] !== 18'h1C200) begin errors++; $display("FAIL ovf_trailer: got %h want 1c200", xq[b + NS + 1]); end
        end
        checks++;
        if (pend_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", pend_overflow); end
    endtask

    task automatic test_reset_mid_stream();
        int b, rb, b2;
        do_reset();
        b = xq.size();
        rb = rcq.size();
        tx_ready = 1'b1;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int i = 0; i < 20 && xq.size() < b + 2; i++) tick();
        checks++;
        if (xq.size() < b + 2) begin errors++; $display("FAIL mid_reach_stream: got %0d transfers want 2", xq.size() - b); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        checks++;
        if ({tx_valid, tx_sof, tx_eof, mem_ren, read_complete, pend_overflow} !== 6'b0 ||
            tx_data !== 16'h0 || mem_raddr !== 5'd0 || n_pending !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got flags=%b data=%h addr=%0d n=%0d want all zero",
                     {tx_valid, tx_sof, tx_eof, mem_ren, read_complete, pend_overflow},
                     tx_data, mem_raddr, n_pending);
        end
        b2 = xq.size();
        repeat (5) tick();
        checks++;
        if (xq.size() != b2 || rcq.size() != rb) begin
            errors++;
            $display("FAIL mid_quiet: got %0d transfers %0d read_complete want 0 0", xq.size() - b2, rcq.size() - rb);
        end
        trig = 1'b1;
        tick();
        trig = 1'b0;
        wait_rc(rb + 1, 40, "mid");
        tick();
        checks++;
        if (xq.size() - b2 != NS + 2) begin
            errors++;
            $display("FAIL mid_restart_count: got %0d transfers want %0d", xq.size() - b2, NS + 2);
        end else begin
            for (int k = 0; k < NS + 2; k++) begin
                checks++;
                if (xq[b2 + k] !== exp_word(0, 0, k, 1'b0)) begin
                    errors++;
                    $display("FAIL mid_restart_word%0d: got %h want %h", k, xq[b2 + k], exp_word(0, 0, k, 1'b0));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_event();
        test_same_cycle();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
